// File: rtl/fdiv_pkg.sv
// Shared types and constants for the divided-tick scheduler.
// Holds the FSM state encoding, default field widths and the legal-parameter minimums.
package fdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DIV_W_DEF = 3;
   localparam int CNT_W_DEF = 4;
   localparam int DIV_MIN   = 2;
   localparam int CNT_MIN   = 1;

endpackage

// File: rtl/fdiv_ctrl_if.sv
// Job handshake bundle between a requester and the divided-tick scheduler.
// The master drives job requests; the slave (scheduler) returns status and ticks.
interface fdiv_ctrl_if #(
   parameter int DIV_W = fdiv_pkg::DIV_W_DEF,
   parameter int CNT_W = fdiv_pkg::CNT_W_DEF
) ();

   logic             start;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] count;
   logic             abort;
   logic             busy;
   logic             tick;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] ticks_left;

   modport master (
      output start, div, count, abort,
      input  busy, tick, done, err, ticks_left
   );

   modport slave (
      input  start, div, count, abort,
      output busy, tick, done, err, ticks_left
   );

endinterface

// File: rtl/fdiv_core.sv
// Divide-by-N phase counter: counts 0..div-1 while enabled and flags the terminal phase.
// The clear input has priority over counting so a new or aborted job always restarts at phase 0.
module fdiv_core #(
   parameter int DIV_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             c_up,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tc
);

   logic [DIV_W-1:0] r_phase;

   assign tc = (r_phase == div - DIV_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase <= '0;
      end else if (clr) begin
         r_phase <= '0;
      end else if (c_up) begin
         r_phase <= tc ? '0 : r_phase + DIV_W'(1);
      end
   end

endmodule

// File: rtl/fdiv_ctrl.sv
// Divided-tick scheduler: accepts a (div, count) job and emits count ticks spaced div cycles apart.
// Owns the job FSM, the latched divide ratio and all registered status outputs.
module fdiv_ctrl
   import fdiv_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic        clk,
   input logic        rst,
   fdiv_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]       r_state;
   logic [DIV_W-1:0] r_div_l;
   logic [CNT_W-1:0] r_ticks_left;
   logic             r_busy;
   logic             r_tick;
   logic             r_done;
   logic             r_err;

   logic w_legal;
   logic w_accept;
   logic w_run;
   logic w_c_up;
   logic w_clr;
   logic w_tc;

   assign w_legal  = (bus.div >= DIV_W'(DIV_MIN)) && (bus.count >= CNT_W'(CNT_MIN));
   assign w_accept = (r_state == S_IDLE) && bus.start && w_legal;
   assign w_run    = (r_state == S_RUN);
   // Abort freezes the counter and clears it, so a coincident terminal phase never ticks.
   assign w_c_up   = w_run && !bus.abort;
   assign w_clr    = w_accept || (w_run && bus.abort);

   fdiv_core #(
      .DIV_W(DIV_W)
   ) u_core (
      .clk  (clk),
      .rst  (rst),
      .c_up (w_c_up),
      .clr  (w_clr),
      .div  (r_div_l),
      .tc   (w_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_div_l      <= '0;
         r_ticks_left <= '0;
         r_busy       <= 1'b0;
         r_tick       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (w_legal) begin
                     r_div_l      <= bus.div;
                     r_ticks_left <= bus.count;
                     r_busy       <= 1'b1;
                     r_state      <= S_RUN;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (bus.abort) begin
                  r_busy       <= 1'b0;
                  r_ticks_left <= '0;
                  r_state      <= S_IDLE;
               end else if (w_tc) begin
                  r_tick       <= 1'b1;
                  r_ticks_left <= r_ticks_left - CNT_W'(1);
                  if (r_ticks_left == CNT_W'(1)) begin
                     r_state <= S_DONE;
                  end
               end
            end
            // Two cycles here: the first raises done, the second drops done and busy together.
            S_DONE: begin
               if (!r_done) begin
                  r_done <= 1'b1;
               end else begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = r_busy;
   assign bus.tick       = r_tick;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   assign bus.ticks_left = r_ticks_left;

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed bench for fdiv_ctrl: expected per-cycle outputs are queued when a job is driven
// and popped against the observed outputs one cycle at a time.
module tb_fdiv_ctrl;

   localparam int DW = 3;
   localparam int CW = 4;

   typedef struct packed {
      logic          busy;
      logic          tick;
      logic          done;
      logic          err;
      logic [CW-1:0] tl;
   } obs_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fdiv_ctrl_if #(.DIV_W(DW), .CNT_W(CW)) bus ();

   fdiv_ctrl #(.DIV_W(DW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   obs_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic obs_t sample();
      obs_t o;
      o.busy = bus.busy;
      o.tick = bus.tick;
      o.done = bus.done;
      o.err  = bus.err;
      o.tl   = bus.ticks_left;
      return o;
   endfunction

   // Expected outputs after edge E0+j of a job (d, c), aborted at edge a when a > 0.
   function automatic obs_t exp_job(int d, int c, int a, int j);
      obs_t e;
      int   cd;
      cd = d * c;
      e  = '0;
      if (a > 0 && j >= a) return e;
      e.busy = (j <= cd + 1);
      e.tick = (j >= 1) && (j <= cd) && (j % d == 0);
      e.done = (j == cd + 1);
      e.tl   = (j <= cd) ? CW'(c - j / d) : '0;
      return e;
   endfunction

   task automatic chk(input string tag);
      obs_t e;
      obs_t o;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         o = sample();
         assert (o === e) else begin
            errors++;
            $error("FAIL %s observed busy=%b tick=%b done=%b err=%b tl=%0d expected busy=%b tick=%b done=%b err=%b tl=%0d",
                   tag, o.busy, o.tick, o.done, o.err, o.tl, e.busy, e.tick, e.done, e.err, e.tl);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // poke: pulse start with a different job during RUN and during DONE.
   // r > 0: assert rst asynchronously between edges r and r+1.
   task automatic run_job(input int d, input int c, input int a, input bit poke, input int r,
                          input string tag);
      int cd;
      int last;
      cd   = d * c;
      last = (r > 0) ? r : ((a > 0) ? a + 1 : cd + 2);
      for (int j = 0; j <= last; j++) sb.push_back(exp_job(d, c, a, j));
      bus.div   = DW'(d);
      bus.count = CW'(c);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.div   = DW'(2);
      bus.count = CW'(15);
      chk(tag);
      for (int j = 1; j <= last; j++) begin
         if (a > 0 && j == a) bus.abort = 1'b1;
         step();
         bus.abort = 1'b0;
         bus.start = poke && (j == d + 1 || j == cd);
         chk(tag);
      end
      bus.start = 1'b0;
      if (r > 0) begin
         #2 rst = 1'b1;
         #1;
         sb.push_back('0);
         chk({tag, "_async_rst"});
         step();
         sb.push_back('0);
         chk({tag, "_rst_hold"});
         rst = 1'b0;
      end
   endtask

   task automatic reject(input int d, input int c, input string tag);
      obs_t e;
      e     = '0;
      e.err = 1'b1;
      sb.push_back(e);
      sb.push_back('0);
      bus.div   = DW'(d);
      bus.count = CW'(c);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk(tag);
      step();
      chk({tag, "_clear"});
   endtask

   task automatic idle_check(input string tag);
      sb.push_back('0);
      step();
      chk(tag);
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.div   = '0;
      bus.count = '0;
      bus.abort = 1'b0;
      step();
      step();
      sb.push_back('0);
      chk("reset");
      rst = 1'b0;
      idle_check("idle_after_reset");

      run_job(5, 3, 0, 1'b0, 0, "d5c3");
      idle_check("idle_d5c3");

      run_job(2, 1, 0, 1'b0, 0, "d2c1");
      run_job(7, 2, 0, 1'b0, 0, "d7c2");

      reject(1, 3, "err_div1");
      reject(4, 0, "err_cnt0");
      reject(0, 5, "err_div0");

      run_job(4, 5, 8, 1'b0, 0, "abort_d4c5");
      idle_check("idle_abort");

      run_job(3, 3, 0, 1'b1, 0, "poke_d3c3");
      idle_check("idle_poke");

      run_job(5, 3, 0, 1'b0, 7, "rst_mid_run");
      run_job(5, 3, 0, 1'b0, 0, "d5c3_after_rst");
      idle_check("idle_final");

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
